pcpi_vec_mem_arbiter: RTL and testbench

PCPI_VEC_MEM_ARBITER -- requirements
Module: pcpi_vec_mem_arbiter

---
 rtl/pcpi_vec_mem_arbiter.sv | 129 ++++++++++++
 tb/tb_pcpi_vec_mem_arbiter.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcpi_vec_mem_arbiter.sv
// ============================================================================
// pcpi_vec_mem_arbiter: two-master (CPU / vector coprocessor) arbiter onto a
// single valid/ready memory port.  Revision: 1.0
// ============================================================================
`default_nettype none

module pcpi_vec_mem_arbiter #(
  parameter int ROUND_ROBIN = 1
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        cpu_mem_valid,
  output logic        cpu_mem_ready,
  input  logic [31:0] cpu_mem_addr,
  input  logic [31:0] cpu_mem_wdata,
  input  logic [3:0]  cpu_mem_wstrb,
  output logic [31:0] cpu_mem_rdata,

  input  logic        vec_mem_valid,
  output logic        vec_mem_ready,
  input  logic [31:0] vec_mem_addr,
  input  logic [31:0] vec_mem_wdata,
  input  logic [3:0]  vec_mem_wstrb,
  output logic [31:0] vec_mem_rdata,

  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,

  output logic        last_grant
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state_q;
  logic        mem_valid_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [3:0]  mem_wstrb_q;
  logic        cpu_ready_q;
  logic        vec_ready_q;
  logic [31:0] cpu_rdata_q;
  logic [31:0] vec_rdata_q;
  logic        last_grant_q;

  logic        cpu_elig;
  logic        vec_elig;
  logic        grant_vec_d;

  assign cpu_elig = cpu_mem_valid & ~cpu_ready_q;
  assign vec_elig = vec_mem_valid & ~vec_ready_q;

  // Vector wins if it is alone, or under round-robin when the CPU went last.
  assign grant_vec_d = vec_elig &
                       (~cpu_elig | ((ROUND_ROBIN != 0) & ~last_grant_q));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      mem_valid_q  <= 1'b0;
      mem_addr_q   <= 32'd0;
      mem_wdata_q  <= 32'd0;
      mem_wstrb_q  <= 4'd0;
      cpu_ready_q  <= 1'b0;
      vec_ready_q  <= 1'b0;
      cpu_rdata_q  <= 32'd0;
      vec_rdata_q  <= 32'd0;
      last_grant_q <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cpu_elig || vec_elig) begin
            last_grant_q <= grant_vec_d;
            mem_addr_q   <= grant_vec_d ? vec_mem_addr  : cpu_mem_addr;
            mem_wdata_q  <= grant_vec_d ? vec_mem_wdata : cpu_mem_wdata;
            mem_wstrb_q  <= grant_vec_d ? vec_mem_wstrb : cpu_mem_wstrb;
            mem_valid_q  <= 1'b1;
            state_q      <= S_REQ;
          end
        end
        S_REQ: begin
          if (mem_ready) begin
            mem_valid_q <= 1'b0;
            if (last_grant_q) begin
              vec_rdata_q <= mem_rdata;
              vec_ready_q <= 1'b1;
            end else begin
              cpu_rdata_q <= mem_rdata;
              cpu_ready_q <= 1'b1;
            end
            state_q <= S_RESP;
          end
        end
        S_RESP: begin
          cpu_ready_q <= 1'b0;
          vec_ready_q <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: begin
          mem_valid_q <= 1'b0;
          cpu_ready_q <= 1'b0;
          vec_ready_q <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_valid     = mem_valid_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign mem_wstrb     = mem_wstrb_q;
  assign cpu_mem_ready = cpu_ready_q;
  assign vec_mem_ready = vec_ready_q;
  assign cpu_mem_rdata = cpu_rdata_q;
  assign vec_mem_rdata = vec_rdata_q;
  assign last_grant    = last_grant_q;

endmodule

`default_nettype wire

// File: tb/tb_pcpi_vec_mem_arbiter.sv
// ============================================================================
// tb_pcpi_vec_mem_arbiter: directed scoreboard bench for both arbitration
// modes (round-robin instance and fixed-priority instance).  Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_pcpi_vec_mem_arbiter;

  logic        clk;
  logic        resetn;
  logic        sel_fp;

  logic        cpu_mem_valid, vec_mem_valid;
  logic [31:0] cpu_mem_addr, cpu_mem_wdata, vec_mem_addr, vec_mem_wdata;
  logic [3:0]  cpu_mem_wstrb, vec_mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  logic        cpu_v_rr, vec_v_rr, cpu_v_fp, vec_v_fp;
  logic        rr_cpu_ready, rr_vec_ready, rr_mem_valid, rr_last_grant;
  logic [31:0] rr_cpu_rdata, rr_vec_rdata, rr_mem_addr, rr_mem_wdata;
  logic [3:0]  rr_mem_wstrb;
  logic        fp_cpu_ready, fp_vec_ready, fp_mem_valid, fp_last_grant;
  logic [31:0] fp_cpu_rdata, fp_vec_rdata, fp_mem_addr, fp_mem_wdata;
  logic [3:0]  fp_mem_wstrb;

  // Bench-side view of whichever instance is currently selected.
  logic        cpu_rdy, vec_rdy, mem_v, lg;
  logic [31:0] cpu_rd, vec_rd, mem_a, mem_wd;
  logic [3:0]  mem_s;

  assign cpu_v_rr = cpu_mem_valid & ~sel_fp;
  assign vec_v_rr = vec_mem_valid & ~sel_fp;
  assign cpu_v_fp = cpu_mem_valid &  sel_fp;
  assign vec_v_fp = vec_mem_valid &  sel_fp;

  assign cpu_rdy = sel_fp ? fp_cpu_ready  : rr_cpu_ready;
  assign vec_rdy = sel_fp ? fp_vec_ready  : rr_vec_ready;
  assign cpu_rd  = sel_fp ? fp_cpu_rdata  : rr_cpu_rdata;
  assign vec_rd  = sel_fp ? fp_vec_rdata  : rr_vec_rdata;
  assign mem_v   = sel_fp ? fp_mem_valid  : rr_mem_valid;
  assign mem_a   = sel_fp ? fp_mem_addr   : rr_mem_addr;
  assign mem_wd  = sel_fp ? fp_mem_wdata  : rr_mem_wdata;
  assign mem_s   = sel_fp ? fp_mem_wstrb  : rr_mem_wstrb;
  assign lg      = sel_fp ? fp_last_grant : rr_last_grant;

  pcpi_vec_mem_arbiter #(.ROUND_ROBIN(1)) u_rr (
    .clk(clk), .resetn(resetn),
    .cpu_mem_valid(cpu_v_rr), .cpu_mem_ready(rr_cpu_ready),
    .cpu_mem_addr(cpu_mem_addr), .cpu_mem_wdata(cpu_mem_wdata),
    .cpu_mem_wstrb(cpu_mem_wstrb), .cpu_mem_rdata(rr_cpu_rdata),
    .vec_mem_valid(vec_v_rr), .vec_mem_ready(rr_vec_ready),
    .vec_mem_addr(vec_mem_addr), .vec_mem_wdata(vec_mem_wdata),
    .vec_mem_wstrb(vec_mem_wstrb), .vec_mem_rdata(rr_vec_rdata),
    .mem_valid(rr_mem_valid), .mem_addr(rr_mem_addr), .mem_wdata(rr_mem_wdata),
    .mem_wstrb(rr_mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .last_grant(rr_last_grant)
  );

  pcpi_vec_mem_arbiter #(.ROUND_ROBIN(0)) u_fp (
    .clk(clk), .resetn(resetn),
    .cpu_mem_valid(cpu_v_fp), .cpu_mem_ready(fp_cpu_ready),
    .cpu_mem_addr(cpu_mem_addr), .cpu_mem_wdata(cpu_mem_wdata),
    .cpu_mem_wstrb(cpu_mem_wstrb), .cpu_mem_rdata(fp_cpu_rdata),
    .vec_mem_valid(vec_v_fp), .vec_mem_ready(fp_vec_ready),
    .vec_mem_addr(vec_mem_addr), .vec_mem_wdata(vec_mem_wdata),
    .vec_mem_wstrb(vec_mem_wstrb), .vec_mem_rdata(fp_vec_rdata),
    .mem_valid(fp_mem_valid), .mem_addr(fp_mem_addr), .mem_wdata(fp_mem_wdata),
    .mem_wstrb(fp_mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .last_grant(fp_last_grant)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } mreq_t;

  typedef struct {
    logic        chk;
    logic [31:0] data;
  } rsp_t;

  mreq_t exp_mem_q[$];
  rsp_t  exp_cpu_q[$];
  rsp_t  exp_vec_q[$];
  bit    grant_trace[$];

  int n_assert = 0;
  int n_fail   = 0;
  int mem_delay = 0;
  bit stray = 1'b0;
  int req_cyc = 0;
  int last_req_cycles = 0;

  logic [31:0] wmem [logic [31:0]];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    logic [31:0] d;
    logic [7:0]  b;
    d = a - 32'h190;
    b = d[7:0];
    return {b + 8'd4, b + 8'd3, b + 8'd2, b + 8'd1};
  endfunction

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (wmem.exists(a)) return wmem[a];
    return init_word(a);
  endfunction

  function automatic logic [31:0] pack_trace();
    logic [31:0] r;
    r = 32'd0;
    foreach (grant_trace[i]) r = {r[30:0], grant_trace[i]};
    return r | (32'(grant_trace.size()) << 16);
  endfunction

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory responder: ready after mem_delay wait cycles, optional stray ready.
  initial begin
    int wcnt;
    logic [31:0] w;
    wcnt = 0;
    mem_ready = 1'b0;
    mem_rdata = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      if (stray) begin
        mem_ready = 1'b1;
      end else if (mem_v) begin
        if (wcnt >= mem_delay) begin
          mem_ready = 1'b1;
          mem_rdata = mem_read(mem_a);
          if (mem_s != 4'd0) begin
            w = mem_read(mem_a);
            for (int i = 0; i < 4; i++)
              if (mem_s[i]) w[8*i +: 8] = mem_wd[8*i +: 8];
            wmem[mem_a] = w;
          end
        end else begin
          mem_ready = 1'b0;
          wcnt++;
        end
      end else begin
        mem_ready = 1'b0;
        wcnt = 0;
      end
    end
  end

  // Memory-side scoreboard: every REQ cycle must present the expected fields.
  initial begin
    forever begin
      @(negedge clk);
      if (resetn && mem_v) begin
        req_cyc++;
        n_assert++;
        assert (exp_mem_q.size() != 0) else begin
          n_fail++;
          $error("FAIL mem_unexpected_req: observed addr=%h expected none", mem_a);
        end
        if (exp_mem_q.size() != 0) begin
          chk32("mem_addr",  mem_a,  exp_mem_q[0].addr);
          chk32("mem_wdata", mem_wd, exp_mem_q[0].wdata);
          chk32("mem_wstrb", {28'd0, mem_s}, {28'd0, exp_mem_q[0].wstrb});
          if (mem_ready) begin
            void'(exp_mem_q.pop_front());
            last_req_cycles = req_cyc;
            req_cyc = 0;
          end
        end
      end
    end
  end

  // Requester-side scoreboard: one ready pulse per expected response.
  initial begin
    rsp_t r;
    forever begin
      @(negedge clk);
      if (resetn && cpu_rdy) begin
        grant_trace.push_back(1'b0);
        chk32("cpu_rdy_vec_low", {31'd0, vec_rdy}, 32'd0);
        chk32("cpu_rdy_last_grant", {31'd0, lg}, 32'd0);
        n_assert++;
        assert (exp_cpu_q.size() != 0) else begin
          n_fail++;
          $error("FAIL cpu_unexpected_ready: observed=1 expected=0");
        end
        if (exp_cpu_q.size() != 0) begin
          r = exp_cpu_q.pop_front();
          if (r.chk) chk32("cpu_rdata", cpu_rd, r.data);
        end
      end
      if (resetn && vec_rdy) begin
        grant_trace.push_back(1'b1);
        chk32("vec_rdy_cpu_low", {31'd0, cpu_rdy}, 32'd0);
        chk32("vec_rdy_last_grant", {31'd0, lg}, 32'd1);
        n_assert++;
        assert (exp_vec_q.size() != 0) else begin
          n_fail++;
          $error("FAIL vec_unexpected_ready: observed=1 expected=0");
        end
        if (exp_vec_q.size() != 0) begin
          r = exp_vec_q.pop_front();
          if (r.chk) chk32("vec_rdata", vec_rd, r.data);
        end
      end
    end
  end

  task automatic set_req(input bit v, input logic va, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] ws);
    if (v) begin
      vec_mem_valid = va; vec_mem_addr = a; vec_mem_wdata = wd; vec_mem_wstrb = ws;
    end else begin
      cpu_mem_valid = va; cpu_mem_addr = a; cpu_mem_wdata = wd; cpu_mem_wstrb = ws;
    end
  endtask

  // Issue n consecutive requests, keeping valid high between them.
  task automatic drive(input bit v, input int n, input logic [31:0] base,
                       input logic [31:0] wd, input logic [3:0] ws, output int lat);
    int t;
    lat = 0;
    for (int i = 0; i < n; i++) begin
      set_req(v, 1'b1, base + 32'(4 * i), wd, ws);
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!(v ? vec_rdy : cpu_rdy) && t < 100);
      if (i == 0) lat = t;
      n_assert++;
      assert (v ? vec_rdy : cpu_rdy) else begin
        n_fail++;
        $error("FAIL %s_ready_timeout: observed=0 expected=1", v ? "vec" : "cpu");
      end
    end
    set_req(v, 1'b0, 32'd0, 32'd0, 4'd0);
  endtask

  task automatic pulse_reset();
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat_c, lat_v, t;
    logic [31:0] w258;
    resetn = 1'b0;
    sel_fp = 1'b0;
    set_req(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    set_req(1'b1, 1'b0, 32'd0, 32'd0, 4'd0);
    repeat (3) @(negedge clk);

    chk32("rst_mem_valid",  {31'd0, mem_v},   32'd0);
    chk32("rst_cpu_ready",  {31'd0, cpu_rdy}, 32'd0);
    chk32("rst_vec_ready",  {31'd0, vec_rdy}, 32'd0);
    chk32("rst_last_grant", {31'd0, lg},      32'd1);
    chk32("rst_mem_addr",   mem_a,  32'd0);
    chk32("rst_mem_wdata",  mem_wd, 32'd0);
    chk32("rst_mem_wstrb",  {28'd0, mem_s}, 32'd0);
    chk32("rst_cpu_rdata",  cpu_rd, 32'd0);
    chk32("rst_vec_rdata",  vec_rd, 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    // CPU-only read, single-cycle memory.
    exp_mem_q.push_back('{32'h190, 32'd0, 4'd0});
    exp_cpu_q.push_back('{1'b1, 32'h04030201});
    drive(1'b0, 1, 32'h190, 32'd0, 4'd0, lat_c);
    chk32("t035_latency_edges", 32'(lat_c), 32'd2);
    chk32("t035_req_cycles", 32'(last_req_cycles), 32'd1);
    chk32("t035_order", pack_trace(), 32'h0001_0000);
    @(negedge clk);
    chk32("t035_rdata_hold", cpu_rd, 32'h04030201);
    grant_trace.delete();

    // Simultaneous first request after reset: CPU wins.
    pulse_reset();
    exp_mem_q.push_back('{32'h0, 32'd0, 4'd0});
    exp_mem_q.push_back('{32'h194, 32'd0, 4'd0});
    exp_cpu_q.push_back('{1'b1, init_word(32'h0)});
    exp_vec_q.push_back('{1'b1, 32'h08070605});
    fork
      drive(1'b0, 1, 32'h0,   32'd0, 4'd0, lat_c);
      drive(1'b1, 1, 32'h194, 32'd0, 4'd0, lat_v);
    join
    chk32("t036_order", pack_trace(), 32'h0002_0001);
    chk32("t036_last_grant", {31'd0, lg}, 32'd1);
    grant_trace.delete();

    // Round-robin contention: C,V,C,V,C,V.
    for (int i = 0; i < 3; i++) begin
      exp_mem_q.push_back('{32'h190 + 32'(4 * i), 32'd0, 4'd0});
      exp_mem_q.push_back('{32'h1A0 + 32'(4 * i), 32'd0, 4'd0});
      exp_cpu_q.push_back('{1'b1, init_word(32'h190 + 32'(4 * i))});
      exp_vec_q.push_back('{1'b1, init_word(32'h1A0 + 32'(4 * i))});
    end
    fork
      drive(1'b0, 3, 32'h190, 32'd0, 4'd0, lat_c);
      drive(1'b1, 3, 32'h1A0, 32'd0, 4'd0, lat_v);
    join
    chk32("t037_order", pack_trace(), 32'h0006_0015);
    grant_trace.delete();

    // Fixed priority: CPU wins every contested grant.
    sel_fp = 1'b1;
    mem_delay = 1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      exp_mem_q.push_back('{32'h190 + 32'(4 * i), 32'd0, 4'd0});
      exp_cpu_q.push_back('{1'b1, init_word(32'h190 + 32'(4 * i))});
      exp_vec_q.push_back('{1'b1, init_word(32'h1A0 + 32'(4 * i))});
    end
    for (int i = 0; i < 3; i++)
      exp_mem_q.push_back('{32'h1A0 + 32'(4 * i), 32'd0, 4'd0});
    fork
      drive(1'b0, 3, 32'h190, 32'd0, 4'd0, lat_c);
      drive(1'b1, 3, 32'h1A0, 32'd0, 4'd0, lat_v);
    join
    chk32("t038_order", pack_trace(), 32'h0006_0007);
    grant_trace.delete();
    sel_fp = 1'b0;
    mem_delay = 0;
    @(negedge clk);

    // Stray mem_ready while idle must be ignored.
    stray = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk32("stray_mem_valid", {31'd0, mem_v}, 32'd0);
    end
    stray = 1'b0;
    @(negedge clk);

    // Vector write, slow memory, requester fields disturbed during REQ.
    mem_delay = 3;
    exp_mem_q.push_back('{32'h258, 32'h00020001, 4'b0011});
    exp_vec_q.push_back('{1'b0, 32'd0});
    fork
      drive(1'b1, 1, 32'h258, 32'h00020001, 4'b0011, lat_v);
      begin
        @(posedge clk);
        @(negedge clk);
        vec_mem_addr  = 32'hDEAD0000;
        vec_mem_wdata = 32'hFFFFFFFF;
        vec_mem_wstrb = 4'hF;
      end
    join
    chk32("t039_req_cycles", 32'(last_req_cycles), 32'd4);
    chk32("t039_order", pack_trace(), 32'h0001_0001);
    grant_trace.delete();
    mem_delay = 0;
    w258 = init_word(32'h258);
    exp_mem_q.push_back('{32'h258, 32'd0, 4'd0});
    exp_cpu_q.push_back('{1'b1, {w258[31:16], 16'h0001}});
    drive(1'b0, 1, 32'h258, 32'd0, 4'd0, lat_c);
    grant_trace.delete();

    // Reset while in REQ abandons the transaction.
    mem_delay = 5;
    exp_mem_q.push_back('{32'h300, 32'd0, 4'd0});
    set_req(1'b1, 1'b1, 32'h300, 32'd0, 4'd0);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!mem_v && t < 20);
    chk32("t040_in_req", {31'd0, mem_v}, 32'd1);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    chk32("t040_rst_mem_valid", {31'd0, mem_v}, 32'd0);
    chk32("t040_rst_last_grant", {31'd0, lg}, 32'd1);
    chk32("t040_rst_mem_addr", mem_a, 32'd0);
    set_req(1'b1, 1'b0, 32'd0, 32'd0, 4'd0);
    exp_mem_q.delete();
    req_cyc = 0;
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk32("t040_no_ready", {30'd0, cpu_rdy, vec_rdy}, 32'd0);
    end
    mem_delay = 0;
    exp_mem_q.push_back('{32'h194, 32'd0, 4'd0});
    exp_vec_q.push_back('{1'b1, 32'h08070605});
    drive(1'b1, 1, 32'h194, 32'd0, 4'd0, lat_v);
    chk32("t040_after_order", pack_trace(), 32'h0001_0001);
    chk32("t040_after_latency", 32'(lat_v), 32'd2);

    repeat (3) @(negedge clk);
    chk32("sb_mem_drain", 32'(exp_mem_q.size()), 32'd0);
    chk32("sb_cpu_drain", 32'(exp_cpu_q.size()), 32'd0);
    chk32("sb_vec_drain", 32'(exp_vec_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
